layer_compositor: RTL and testbench

- Parametrised multi-layer pixel compositor for the XVGA display path; generalises the fixed 3-sprite priority mux and fixed 6-stage sync delay of the game top level.
- Takes NLAYERS sprite pixel streams (layer 0 = highest priority) plus raw hsync/vsync/blank; outputs one registered pixel with sync and blank delayed to match.
- Adds a per-layer enable mask, a colour-key transparency test, a saturating additive blend mode, a background colour, and per-frame overlap (collision) flags for the game state machines.

---
 rtl/layer_compositor.sv | 142 ++++++++++++++
 tb/tb_layer_compositor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Multi-layer pixel compositor for the XVGA path: delays hsync/vsync/blank,
// merges NLAYERS sprite streams by priority or saturating add, and reports
// per-frame layer overlaps at each pvsync falling edge.
module layer_compositor #(
    parameter int                NLAYERS    = 4,
    parameter int                CHW        = 8,
    parameter int                SYNC_DELAY = 6,
    parameter logic [3*CHW-1:0]  KEY        = '0
) (
    input  logic                       vclock,
    input  logic                       reset_n,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic                       blank,
    input  logic [NLAYERS*3*CHW-1:0]   layer_pix,
    input  logic [NLAYERS-1:0]         layer_en,
    input  logic                       blend_mode,
    input  logic [3*CHW-1:0]           bg_color,
    output logic [3*CHW-1:0]           pixel,
    output logic                       phsync,
    output logic                       pvsync,
    output logic                       pblank,
    output logic [NLAYERS-1:0]         collide,
    output logic                       frame_done
);
    localparam int PW = 3 * CHW;
    localparam int SW = CHW + 3;
    localparam logic [SW-1:0] CH_MAX = {3'b000, {CHW{1'b1}}};

    // Stage k of the delay line lives at index k; index 0 is the raw input.
    logic [SYNC_DELAY:1] hs_q, vs_q, bl_q;
    logic [SYNC_DELAY:0] hs_s, vs_s, bl_s;

    logic [NLAYERS-1:0] op, ovl, contrib;
    logic [NLAYERS-1:0] acc_q, acc_d, collide_q, collide_d;
    logic               fd_q, fd_d;
    logic [PW-1:0]      pix_q, pix_d;
    logic               blank_al, frame_fall;

    assign hs_s = {hs_q, hsync};
    assign vs_s = {vs_q, vsync};
    assign bl_s = {bl_q, blank};

    // Blank as seen by the layer pixels arriving this cycle.
    assign blank_al   = bl_s[SYNC_DELAY-1];
    // pvsync is about to fall on this clock edge.
    assign frame_fall = vs_s[SYNC_DELAY] & ~vs_s[SYNC_DELAY-1];

    // Sync/blank delay line; idle level is all ones (sync inactive, blanked).
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            hs_q <= '1;
            vs_q <= '1;
            bl_q <= '1;
        end else begin
            hs_q <= hs_s[SYNC_DELAY-1:0];
            vs_q <= vs_s[SYNC_DELAY-1:0];
            bl_q <= bl_s[SYNC_DELAY-1:0];
        end
    end

    // Opaque test and "opaque together with another layer" overlap vector.
    always_comb begin
        logic [NLAYERS-1:0] others;
        op     = '0;
        ovl    = '0;
        others = '0;
        for (int i = 0; i < NLAYERS; i++)
            op[i] = layer_en[i] & (layer_pix[i*PW +: PW] != KEY);
        for (int i = 0; i < NLAYERS; i++) begin
            others    = op;
            others[i] = 1'b0;
            ovl[i]    = op[i] & (|others);
        end
        contrib = blank_al ? '0 : ovl;
    end

    // Next pixel: blank, background, priority pick or saturating add.
    always_comb begin
        logic [SW-1:0] sr, sg, sb;
        logic [PW-1:0] first;
        sr    = '0;
        sg    = '0;
        sb    = '0;
        first = '0;
        // Walk from the top index down so the lowest-index opaque layer wins.
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (op[i]) first = layer_pix[i*PW +: PW];
        end
        for (int i = 0; i < NLAYERS; i++) begin
            if (op[i]) begin
                sr = sr + {3'b000, layer_pix[i*PW + 2*CHW +: CHW]};
                sg = sg + {3'b000, layer_pix[i*PW +   CHW +: CHW]};
                sb = sb + {3'b000, layer_pix[i*PW         +: CHW]};
            end
        end
        if (blank_al)
            pix_d = '0;
        else if (op == '0)
            pix_d = bg_color;
        else if (!blend_mode)
            pix_d = first;
        else
            pix_d = {(sr > CH_MAX) ? CH_MAX[CHW-1:0] : sr[CHW-1:0],
                     (sg > CH_MAX) ? CH_MAX[CHW-1:0] : sg[CHW-1:0],
                     (sb > CH_MAX) ? CH_MAX[CHW-1:0] : sb[CHW-1:0]};
    end

    // Collision accumulation and frame-boundary publish of the flags.
    always_comb begin
        acc_d     = acc_q | contrib;
        collide_d = collide_q;
        fd_d      = 1'b0;
        if (frame_fall) begin
            collide_d = acc_q | contrib;
            acc_d     = '0;
            fd_d      = 1'b1;
        end
    end

    // Output pixel, collision state and frame pulse registers.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            pix_q     <= '0;
            acc_q     <= '0;
            collide_q <= '0;
            fd_q      <= 1'b0;
        end else begin
            pix_q     <= pix_d;
            acc_q     <= acc_d;
            collide_q <= collide_d;
            fd_q      <= fd_d;
        end
    end

    assign pixel      = pix_q;
    assign phsync     = hs_q[SYNC_DELAY];
    assign pvsync     = vs_q[SYNC_DELAY];
    assign pblank     = bl_q[SYNC_DELAY];
    assign collide    = collide_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor (NLAYERS=4, CHW=8, SYNC_DELAY=6, KEY=0):
// history-based reference model compared every cycle, plus directed
// literal expectations.
module tb_layer_compositor;
    logic        vclock = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
    logic [95:0] layer_pix = '0;
    logic [3:0]  layer_en = '0;
    logic        blend_mode = 1'b0;
    logic [23:0] bg_color = '0;
    logic [23:0] pixel;
    logic        phsync, pvsync, pblank, frame_done;
    logic [3:0]  collide;

    int n_pass = 0;
    int n_total = 0;

    layer_compositor #(.NLAYERS(4), .CHW(8), .SYNC_DELAY(6), .KEY(24'h0)) dut (
        .vclock(vclock), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .blank(blank), .layer_pix(layer_pix), .layer_en(layer_en),
        .blend_mode(blend_mode), .bg_color(bg_color), .pixel(pixel),
        .phsync(phsync), .pvsync(pvsync), .pblank(pblank),
        .collide(collide), .frame_done(frame_done)
    );

    always #5 vclock = ~vclock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic step();
        @(negedge vclock);
    endtask

    // Reference compositing rule straight from the colour arithmetic.
    function automatic logic [23:0] model_pix(input logic [95:0] lp, input logic [3:0] en,
                                              input logic mode, input logic [23:0] bg);
        int r, g, b;
        bit any;
        logic [23:0] first, p;
        r = 0; g = 0; b = 0; any = 0; first = '0;
        for (int i = 0; i < 4; i++) begin
            p = lp[i*24 +: 24];
            if (en[i] && p != 24'h0) begin
                if (!any) first = p;
                any = 1;
                r += p[23:16]; g += p[15:8]; b += p[7:0];
            end
        end
        if (!any) return bg;
        if (!mode) return first;
        if (r > 255) r = 255;
        if (g > 255) g = 255;
        if (b > 255) b = 255;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Model: h*[k] is the input sampled k edges before the latest one.
    bit          hh[0:6], vh[0:6], bh[0:6];
    logic [3:0]  m_acc, m_col;
    logic        m_fd;
    logic [23:0] m_pix;

    always @(posedge vclock) begin
        logic [3:0] opq, ov;
        int cnt;
        if (!reset_n) begin
            for (int k = 0; k < 7; k++) begin hh[k] = 1; vh[k] = 1; bh[k] = 1; end
            m_acc = '0; m_col = '0; m_fd = 0; m_pix = '0;
        end else begin
            for (int k = 6; k > 0; k--) begin hh[k] = hh[k-1]; vh[k] = vh[k-1]; bh[k] = bh[k-1]; end
            hh[0] = hsync; vh[0] = vsync; bh[0] = blank;
            m_pix = bh[5] ? 24'h0 : model_pix(layer_pix, layer_en, blend_mode, bg_color);
            cnt = 0;
            for (int i = 0; i < 4; i++) begin
                opq[i] = layer_en[i] && (layer_pix[i*24 +: 24] != 24'h0);
                if (opq[i]) cnt++;
            end
            ov = (cnt >= 2 && !bh[5]) ? opq : 4'b0000;
            if (!vh[5] && vh[6]) begin
                m_col = m_acc | ov; m_acc = '0; m_fd = 1;
            end else begin
                m_acc = m_acc | ov; m_fd = 0;
            end
        end
        #1;
        chk("pixel", {8'h0, pixel}, {8'h0, m_pix});
        chk("sync hs/vs/blank", {29'h0, phsync, pvsync, pblank},
            {29'h0, (reset_n ? {hh[5], vh[5], bh[5]} : 3'b111)});
        chk("collide/frame_done", {27'h0, collide, frame_done}, {27'h0, m_col, m_fd});
    end

    // Pulse vsync low one cycle and wait (bounded) for the frame_done pulse.
    task automatic frame_pulse(input bit do_chk, input logic [3:0] exp_col, input string name);
        bit found;
        found = 0;
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (frame_done) found = 1;
            else step();
        end
        if (!found) chk({name, " frame_done timeout"}, 32'd0, 32'd1);
        else if (do_chk) chk({name, " collide"}, {28'h0, collide}, {28'h0, exp_col});
        step();
        if (do_chk) chk({name, " frame_done one cycle"}, {31'h0, frame_done}, 32'd0);
    endtask

    task automatic overlap_1_3();
        layer_pix = {24'h123456, 24'h0, 24'h00FF00, 24'h0};
        step();
        layer_pix = '0;
    endtask

    initial begin
        repeat (3) step();
        chk("reset pixel", {8'h0, pixel}, 32'h0);
        chk("reset sync", {29'h0, phsync, pvsync, pblank}, 32'h7);
        chk("reset collide/fd", {27'h0, collide, frame_done}, 32'h0);
        reset_n = 1'b1;
        step();

        // hsync pulse and blank release show up exactly 6 edges later
        hsync = 1'b0; blank = 1'b0;
        step();
        hsync = 1'b1;
        repeat (4) step();
        chk("sync at 5 edges", {30'h0, phsync, pblank}, 32'h3);
        step();
        chk("sync at 6 edges", {30'h0, phsync, pblank}, 32'h0);
        step();
        chk("sync at 7 edges", {30'h0, phsync, pblank}, 32'h0 | 32'h2);

        // priority mode
        layer_en  = 4'b1111;
        layer_pix = {24'h0, 24'hFF0000, 24'h00FF00, 24'h0};
        step();
        chk("priority 1111", {8'h0, pixel}, 32'h00FF00);
        layer_en = 4'b1101;
        step();
        chk("priority 1101", {8'h0, pixel}, 32'hFF0000);
        layer_pix = '0; bg_color = 24'h101010;
        step();
        chk("background", {8'h0, pixel}, 32'h101010);

        // additive mode with saturation, then blank at the aligned stage
        blend_mode = 1'b1; layer_en = 4'b1111;
        layer_pix  = {24'h0, 24'h60A001, 24'hC08000, 24'h0};
        step();
        chk("additive sat", {8'h0, pixel}, 32'hFFFF01);
        blank = 1'b1;
        repeat (5) step();
        chk("additive before blank", {8'h0, pixel}, 32'hFFFF01);
        step();
        chk("blank forces 0", {8'h0, pixel}, 32'h0);
        blank = 1'b0; layer_pix = '0; blend_mode = 1'b0; bg_color = '0;
        repeat (8) step();

        // clear whatever overlaps earlier tests left, then frame collision
        frame_pulse(0, 4'b0000, "flush");
        repeat (3) step();
        overlap_1_3();
        repeat (3) step();
        frame_pulse(1, 4'b1010, "overlap 1,3");
        repeat (3) step();
        frame_pulse(1, 4'b0000, "no overlap");

        // disabled layer 3 gives no collision
        layer_en = 4'b0111;
        overlap_1_3();
        layer_en = 4'b1111;
        frame_pulse(1, 4'b0000, "layer3 disabled");

        // overlap during blank is not counted
        blank = 1'b1;
        repeat (6) step();
        overlap_1_3();
        repeat (6) step();
        blank = 1'b0;
        repeat (6) step();
        frame_pulse(1, 4'b0000, "overlap in blank");

        // reset mid-frame discards collide and the accumulator
        overlap_1_3();
        frame_pulse(1, 4'b1010, "pre-reset overlap");
        overlap_1_3();
        reset_n = 1'b0;
        step();
        chk("collide in reset", {28'h0, collide}, 32'h0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (8) step();
        frame_pulse(1, 4'b0000, "after reset");

        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
